// File: rtl/capture_pkg.sv
// capture_pkg
// Shared constants and state type for the capture path.
// Imported by capture_ctrl, the capture RAM and the host command decoder.
//   DEPTH   : capture RAM entries
//   ADDR_W  : capture RAM address width, log2(DEPTH)
//   CNT_W   : sample counter width; one extra bit so that DEPTH itself fits
package capture_pkg;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_ctrl.sv
// capture_ctrl
// Ring-buffer capture sequencer. Fills the capture RAM with enough
// pre-trigger samples that, together with the requested post-trigger count,
// the buffer is always full when the capture completes.
//
// Ports
//   clk               sole clock, rising edge
//   rst               synchronous active-high reset
//   cap_en            host start request, accepted only in IDLE
//   trig_pos          post-trigger sample count, latched with cap_en
//   smpl              sample strobe, one RAM write per cycle while capturing
//   triggered         trigger flag from the trigger logic
//   clr_done          host acknowledge, releases DONE
//   armed             trigger qualification enable (high only in ARMED)
//   set_capture_done  one-cycle pulse on entry to DONE
//   we                capture RAM write enable (combinational)
//   waddr             capture RAM write address
//   cap_done          sticky capture-complete status
//   trig_addr         oldest sample of the completed buffer
//
// state | meaning
// IDLE  | waiting for cap_en
// PRE   | collecting the DEPTH-post_tgt mandatory pre-trigger samples
// ARMED | buffer primed, waiting for triggered
// POST  | collecting post_tgt post-trigger samples
// DONE  | capture complete, waiting for clr_done
module capture_ctrl
  import capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              smpl,
  input  logic              triggered,
  input  logic              clr_done,
  output logic              armed,
  output logic              set_capture_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              cap_done,
  output logic [ADDR_W-1:0] trig_addr
);

  cap_state_t        state;
  cap_state_t        state_nxt;
  logic [CNT_W-1:0]  post_tgt;
  logic [CNT_W-1:0]  pre_tgt;
  logic [CNT_W-1:0]  smpl_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] waddr_nxt;
  logic              capturing;
  logic              pre_tc;
  logic              post_tc;
  logic              enter_done;

  assign capturing = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);

  // Reset masks the write so a capture interrupted by rst never touches RAM
  // in the reset cycle.
  assign we = capturing & smpl & ~rst;

  assign waddr_nxt = !we ? waddr :
                     (waddr == ADDR_W'(DEPTH - 1)) ? '0 : waddr + ADDR_W'(1);

  // Pre-trigger target ranges 1..DEPTH, hence the extra counter bit.
  assign pre_tgt = CNT_W'(DEPTH) - post_tgt;
  assign cnt_inc = smpl_cnt + CNT_W'(1);
  assign pre_tc  = smpl & (cnt_inc == pre_tgt);
  assign post_tc = smpl & (cnt_inc == post_tgt);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cap_en) state_nxt = ST_PRE;
      ST_PRE:   if (pre_tc) state_nxt = ST_ARMED;
      ST_ARMED: if (triggered) state_nxt = (post_tgt == '0) ? ST_DONE : ST_POST;
      ST_POST:  if (post_tc) state_nxt = ST_DONE;
      ST_DONE:  if (clr_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign enter_done = (state != ST_DONE) && (state_nxt == ST_DONE);
  assign armed      = (state == ST_ARMED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      waddr            <= '0;
      trig_addr        <= '0;
      cap_done         <= 1'b0;
      set_capture_done <= 1'b0;
      post_tgt         <= '0;
      smpl_cnt         <= '0;
    end else begin
      state            <= state_nxt;
      waddr            <= waddr_nxt;
      set_capture_done <= enter_done;

      // The counter is reused for both sample phases; it restarts at each
      // phase boundary.
      if (state == ST_IDLE && cap_en) begin
        post_tgt <= {1'b0, trig_pos};
        smpl_cnt <= '0;
      end else if (state == ST_PRE && smpl) begin
        smpl_cnt <= pre_tc ? '0 : cnt_inc;
      end else if (state == ST_ARMED && triggered) begin
        smpl_cnt <= '0;
      end else if (state == ST_POST && smpl) begin
        smpl_cnt <= cnt_inc;
      end

      // The buffer is full at this point, so the slot after the last write
      // holds the oldest sample.
      if (enter_done) begin
        cap_done  <= 1'b1;
        trig_addr <= waddr_nxt;
      end else if (state == ST_DONE && clr_done) begin
        cap_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;
  import capture_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cap_en;
  logic [ADDR_W-1:0] trig_pos;
  logic              smpl;
  logic              triggered;
  logic              clr_done;
  logic              armed;
  logic              set_capture_done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              cap_done;
  logic [ADDR_W-1:0] trig_addr;

  capture_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .cap_en           (cap_en),
    .trig_pos         (trig_pos),
    .smpl             (smpl),
    .triggered        (triggered),
    .clr_done         (clr_done),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .we               (we),
    .waddr            (waddr),
    .cap_done         (cap_done),
    .trig_addr        (trig_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              we;
    logic              armed;
    logic              cap_done;
    logic [ADDR_W-1:0] trig_addr;
  } lvl_t;

  lvl_t lvl_q[$];
  int   wr_q[$];
  int   done_q[$];

  // Reference model in terms of the capture rules: a phase number, the ring
  // address, and how many pre/post samples are still owed.
  int m_phase;       // 0 idle, 1 filling, 2 waiting trigger, 3 post, 4 complete
  int m_addr;
  int m_post;
  int m_pre_left;
  int m_post_left;
  int m_trig_addr;
  bit m_valid = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_capture();
    m_phase     = 4;
    m_trig_addr = m_addr;
    done_q.push_back(m_addr);
  endtask

  task automatic step(input bit en, input int tp, input bit s, input bit t,
                      input bit c, input bit r);
    bit   wrote;
    lvl_t l;
    @(posedge clk); #1;
    rst = r; cap_en = en; trig_pos = ADDR_W'(tp); smpl = s; triggered = t; clr_done = c;
    cyc++;
    wrote = s && (m_phase >= 1 && m_phase <= 3) && !r;
    if (m_valid) begin
      l.we        = wrote;
      l.armed     = (m_phase == 2);
      l.cap_done  = (m_phase == 4);
      l.trig_addr = ADDR_W'(m_trig_addr);
      lvl_q.push_back(l);
    end
    if (r) begin
      m_phase = 0; m_addr = 0; m_trig_addr = 0; m_post = 0; m_valid = 1;
      return;
    end
    if (wrote) begin
      wr_q.push_back(m_addr);
      m_addr = (m_addr + 1) % DEPTH;
    end
    case (m_phase)
      0: if (en) begin
           m_phase    = 1;
           m_post     = tp % DEPTH;
           m_pre_left = DEPTH - m_post;
         end
      1: if (wrote) begin
           m_pre_left--;
           if (m_pre_left == 0) m_phase = 2;
         end
      2: if (t) begin
           if (m_post == 0) finish_capture();
           else begin
             m_phase     = 3;
             m_post_left = m_post;
           end
         end
      3: if (wrote) begin
           m_post_left--;
           if (m_post_left == 0) finish_capture();
         end
      4: if (c) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  function automatic bit smp(input int period);
    if (period == 0) return bit'($urandom_range(0, 1));
    return (cyc % period) == 0;
  endfunction

  task automatic reset_check();
    @(negedge clk);
    chk("rst_waddr", waddr, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_armed", armed, 0);
    chk("rst_cap_done", cap_done, 0);
    chk("rst_set_capture_done", set_capture_done, 0);
    chk("rst_we", we, 0);
  endtask

  task automatic capture(input int tp, input int period, input int arm_wait,
                         input bit pre_trig, input bit trig_smpl, input bit rst_in_post);
    int guard;
    int post_cycles;
    step(1, tp, 0, 0, 0, 0);
    guard = 0;
    while (m_phase == 1 && guard < 5000) begin
      step(0, int'($urandom), smp(period), pre_trig && ($urandom_range(0, 3) == 0), 0, 0);
      guard++;
    end
    if (guard >= 5000) begin
      errors++;
      $display("FAIL pre_phase_timeout: got %0d cycles expected under 5000", guard);
      return;
    end
    for (int i = 0; i < arm_wait; i++)
      step(bit'($urandom_range(0, 1)), int'($urandom), smp(period), 0, 0, 0);
    step(0, int'($urandom), trig_smpl ? 1'b1 : smp(period), 1, 0, 0);
    guard = 0;
    post_cycles = 0;
    while (m_phase == 3 && guard < 5000) begin
      if (rst_in_post && post_cycles == 5) begin
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        reset_check();
        return;
      end
      step(bit'($urandom_range(0, 1)), int'($urandom), smp(period), 1, 0, 0);
      guard++;
      post_cycles++;
    end
    if (guard >= 5000) begin
      errors++;
      $display("FAIL post_phase_timeout: got %0d cycles expected under 5000", guard);
      return;
    end
    for (int i = 0; i < 3; i++)
      step(bit'($urandom_range(0, 1)), int'($urandom), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), 0, 0);
    step(0, int'($urandom), bit'($urandom_range(0, 1)), 0, 1, 0);
    step(0, int'($urandom), bit'($urandom_range(0, 1)), 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    lvl_t l;
    int   e;
    forever begin
      @(negedge clk);
      if (lvl_q.size() > 0) begin
        l = lvl_q.pop_front();
        chk("we", we, l.we);
        chk("armed", armed, l.armed);
        chk("cap_done", cap_done, l.cap_done);
        chk("trig_addr", trig_addr, l.trig_addr);
      end
      if (we === 1'b1) begin
        chk("write_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("waddr", waddr, e);
        end
      end
      if (set_capture_done === 1'b1) begin
        chk("done_pulse_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          e = done_q.pop_front();
          chk("done_trig_addr", trig_addr, e);
          chk("done_waddr", waddr, e);
          chk("done_cap_done", cap_done, 1);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cap_en = 1'b0; trig_pos = '0; smpl = 1'b0; triggered = 1'b0; clr_done = 1'b0;
    m_phase = 0; m_addr = 0; m_post = 0; m_pre_left = 0; m_post_left = 0; m_trig_addr = 0;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 1, 1);
    step(0, int'($urandom), 1, 1, 0, 0);
    reset_check();

    capture(100, 1, 187, 0, 0, 0);   // trigger around cycle 600
    capture(0,   0, 3,   1, 0, 0);   // PRE triggers ignored, direct DONE
    capture(511, 3, 4,   0, 0, 0);   // one pre write, 511 post writes
    capture(10,  0, 6,   0, 1, 0);   // trigger and sample together
    capture(50,  1, 2,   0, 0, 1);   // reset in POST
    capture(37,  1, 1,   0, 0, 0);   // restart after reset
    for (int k = 0; k < 4; k++)
      capture(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), 0);

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameters SHALL come from capture_pkg: DEPTH default 512 (capture RAM entries); ADDR_W default 9 (log2(DEPTH)).
REQ-002 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 cap_en  in  1  single-cycle host request to start a capture.
REQ-005 trig_pos  in  ADDR_W  post-trigger sample count; sampled only when cap_en is accepted.
REQ-006 smpl  in  1  sample strobe from decimator; one RAM write per asserted cycle while capturing.
REQ-007 triggered  in  1  trigger flag from trigger logic; cleared by that logic after set_capture_done.
REQ-008 clr_done  in  1  host acknowledge; releases DONE.
REQ-009 armed  out  1  enables trigger qualification downstream.
REQ-010 set_capture_done  out  1  single-cycle pulse to clear the trigger flag.
REQ-011 we  out  1  capture RAM write enable.
REQ-012 waddr  out  ADDR_W  capture RAM write address.
REQ-013 cap_done  out  1  sticky capture-complete status.
REQ-014 trig_addr  out  ADDR_W  address of oldest sample in the completed buffer.

Function
REQ-015 FSM states SHALL be IDLE, PRE, ARMED, POST, DONE.
REQ-016 IDLE->PRE on cap_en: latch trig_pos into post_tgt, clear sample counter. waddr is retained.
REQ-017 cap_en SHALL be ignored in every state other than IDLE.
REQ-018 we SHALL equal smpl in PRE, ARMED and POST, and 0 in IDLE and DONE; combinational, same cycle.
REQ-019 waddr SHALL increment by 1 after each write and wrap from DEPTH-1 to 0.
REQ-020 PRE->ARMED on the cycle that writes pre-sample number DEPTH-post_tgt. That sample is counted, and armed rises the next cycle.
REQ-021 armed SHALL be 1 exactly while in ARMED. triggered SHALL be ignored in PRE.
REQ-022 In ARMED, triggered=1 with post_tgt!=0 SHALL go to POST. A smpl in the same cycle is written as a pre-trigger sample.
REQ-023 In ARMED, triggered=1 with post_tgt==0 SHALL go directly to DONE.
REQ-024 POST->DONE on the cycle that writes post-sample number post_tgt. That sample is written.
REQ-025 On entry to DONE, set_capture_done SHALL pulse for exactly one cycle.
REQ-026 On entry to DONE, cap_done SHALL set, and trig_addr SHALL load the next waddr (oldest entry, since the buffer is full).
REQ-027 DONE->IDLE on clr_done, clearing cap_done; trig_addr SHALL hold.
REQ-028 Invariant: writes per capture SHALL be >= DEPTH, so the ring buffer is always full at DONE.
REQ-029 Counters SHALL be ADDR_W+1 bits so DEPTH-post_tgt (range 1..DEPTH) is representable without overflow.

Reset
REQ-030 rst SHALL force IDLE with armed=0, set_capture_done=0, cap_done=0, waddr=0, trig_addr=0 and counters=0 on the next clk edge, from any state.
REQ-031 rst SHALL take priority over every other input, including mid-capture. No set_capture_done pulse SHALL result from a reset.
REQ-032 we SHALL be 0 in the reset cycle.

Structure
REQ-033 capture_pkg SHALL hold DEPTH, ADDR_W and the state enum cap_state_t, shared with the RAM and host command decoder.
REQ-034 Single module; no sub-module (counters and FSM are small enough inline).

Verification
REQ-035 trig_pos=100, smpl every cycle, triggered at cycle 600 -> armed after 412 writes; set_capture_done 1 pulse after 100 further writes; cap_done=1; trig_addr=waddr.
REQ-036 trig_pos=0, triggered asserted during PRE and again during ARMED -> PRE trigger ignored; DONE on the first ARMED trigger with no post writes.
REQ-037 trig_pos=511, smpl every 3rd cycle -> armed after exactly 1 write; 511 post writes; waddr wraps 511->0 correctly.
REQ-038 cap_en pulsed during ARMED and DONE -> ignored. clr_done -> IDLE with cap_done=0; a new cap_en then restarts the capture.
REQ-039 rst asserted in POST -> next cycle IDLE, all outputs 0, no set_capture_done pulse.
REQ-040 triggered and smpl in the same ARMED cycle, trig_pos=10 -> that sample is written and exactly 10 more writes precede DONE.
